decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decodeQueue

Interface
REQ-001 Parameter width, default 32: data width of PC and instruction fields.
REQ-002 Parameter depth, default 4: queue entries; the design SHALL support any power of two from 2 to 16.
REQ-003 Local parameter cw = $clog2(depth)+1: width of the occupancy count.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 push_F  input  1  fetch presents a valid packet this cycle.
REQ-007 hit_F  input  1  BTB hit flag for the pushed packet.
REQ-008 predBJ_F  input  1  predicted-taken flag for the pushed packet.
REQ-009 pc_F  input  width  PC of the pushed packet.
REQ-010 instr_F  input  width  instruction word of the pushed packet.
REQ-011 full_F  output  1  queue holds depth entries; fetch SHALL NOT push unless a pop occurs in the same cycle.
REQ-012 stall_D  input  1  decode cannot consume the head entry this cycle.
REQ-013 flush_DF  input  1  branch/jump redirect; discards all entries.
REQ-014 valid_D  output  1  the head entry is valid.
REQ-015 hit_D, predBJ_D  output  1 each  head entry flags.
REQ-016 pc_D, instr_D  output  width each  head entry PC and instruction.
REQ-017 rs_D, rt_D, rd_D  output  5 each  instr_D[25:21], [20:16], [15:11].
REQ-018 count_D  output  cw  current occupancy, 0..depth.
REQ-019 overflow_F  output  1  sticky error: a push was dropped.

Function
REQ-020 Storage: depth-entry circular buffer of {hit, predBJ, pc, instr} (2*width+2 bits), with read pointer, write pointer (log2(depth) bits, natural wrap from depth-1 to 0) and count register.
REQ-021 pop = valid_D & ~stall_D; push_ok = push_F & (~full_F | pop).
REQ-022 valid_D = (count_D != 0); full_F = (count_D == depth); both derived combinationally from count.
REQ-023 Head outputs SHALL show the entry at the read pointer combinationally, giving zero-cycle latency from register to output; a pushed packet SHALL be visible at the head no earlier than the cycle after the push (no bypass).
REQ-024 When valid_D=0, hit_D, predBJ_D, pc_D and instr_D SHALL all be 0, so that instr_D decodes as a NOP (sll $0,$0,0).
REQ-025 On pop, the read pointer SHALL advance by 1; on push_ok, the entry SHALL be written at the write pointer and the write pointer SHALL advance by 1.
REQ-026 Count update: +1 on push_ok only; -1 on pop only; unchanged when both occur or neither occurs.
REQ-027 Push and pop in the same cycle while full SHALL be accepted; count SHALL stay at depth.
REQ-028 Push and pop in the same cycle while count=1 SHALL leave count=1, with the new packet at the head in the next cycle.
REQ-029 A push while full with no pop SHALL be dropped, leave all state unchanged, and set overflow_F=1 until reset.
REQ-030 flush_DF has priority over all other events: in the next cycle, pointers and count SHALL be 0 and a same-cycle push SHALL be discarded (not counted as overflow).
REQ-031 stall_D with valid_D=0 SHALL have no effect; pushes SHALL continue while stall_D=1 until the queue is full.
REQ-032 Storage array contents need not be reset; outputs SHALL be masked per REQ-024.

Reset
REQ-033 While reset=0, regardless of clk: pointers=0, count_D=0, overflow_F=0, hence valid_D=0, full_F=0, and all head outputs 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately; after release, the first rising edge SHALL accept a push normally.

Verification
REQ-035 Push pc 0x100, 0x104, 0x108 with stall_D=1 -> count_D=3, valid_D=1, pc_D=0x100; release stall -> pc_D=0x104, 0x108 on the following cycles, then valid_D=0 and instr_D=0.
REQ-036 depth=4: push 4 entries with stall_D=1 -> full_F=1; a 5th push -> dropped, count_D=4, overflow_F=1; the head is unchanged.
REQ-037 Full queue, push 0x200 with stall_D=0 -> count_D stays 4; after a 4-pop drain, the last pc_D is 0x200.
REQ-038 count_D=3 with push_F=1 and flush_DF=1 -> next cycle count_D=0, valid_D=0, overflow_F unchanged.
REQ-039 Push/pop continuously for 3*depth packets with incrementing PCs -> output order equals input order across pointer wrap, with count_D constant at 1.
REQ-040 reset=0 asserted between clock edges with count_D=2 -> outputs go to 0 before the next edge; a push after release appears at the head one cycle later.

Source files
------------

// File: rtl/decode_queue.sv
// Fetch-to-decode packet queue: circular buffer of {hit, predBJ, pc, instr}
// with combinational head outputs, flush, overflow detection and occupancy count.
module decode_queue #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 4,
  localparam int unsigned cw = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_F,
  input  logic             hit_F,
  input  logic             predBJ_F,
  input  logic [width-1:0] pc_F,
  input  logic [width-1:0] instr_F,
  output logic             full_F,
  input  logic             stall_D,
  input  logic             flush_DF,
  output logic             valid_D,
  output logic             hit_D,
  output logic             predBJ_D,
  output logic [width-1:0] pc_D,
  output logic [width-1:0] instr_D,
  output logic [4:0]       rs_D,
  output logic [4:0]       rt_D,
  output logic [4:0]       rd_D,
  output logic [cw-1:0]    count_D,
  output logic             overflow_F
);

  localparam int unsigned aw = $clog2(depth);

  typedef struct packed {
    logic             hit;
    logic             pred_bj;
    logic [width-1:0] pc;
    logic [width-1:0] instr;
  } entry_t;

  entry_t          mem_q [depth];
  logic [aw-1:0]   rd_q, rd_d;
  logic [aw-1:0]   wr_q, wr_d;
  logic [cw-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            wr_en;
  logic            pop;
  logic            push_ok;
  entry_t          head;

  assign valid_D    = (count_q != '0);
  assign full_F     = (count_q == cw'(depth));
  assign count_D    = count_q;
  assign overflow_F = overflow_q;

  assign pop     = valid_D & ~stall_D;
  assign push_ok = push_F & (~full_F | pop);

  // Head is masked to all-zero when empty so instr_D decodes as a NOP.
  assign head     = valid_D ? mem_q[rd_q] : '0;
  assign hit_D    = head.hit;
  assign predBJ_D = head.pred_bj;
  assign pc_D     = head.pc;
  assign instr_D  = head.instr;
  assign rs_D     = head.instr[25:21];
  assign rt_D     = head.instr[20:16];
  assign rd_D     = head.instr[15:11];

  // Next-state: flush wins over everything, including a same-cycle push.
  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (flush_DF) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rd_d = rd_q + aw'(1);
      end
      if (push_ok) begin
        wr_en = 1'b1;
        wr_d  = wr_q + aw'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + cw'(1);
      end else if (pop && !push_ok) begin
        count_d = count_q - cw'(1);
      end
      if (push_F && !push_ok) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; reads are masked by valid_D.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q] <= {hit_F, predBJ_F, pc_F, instr_F};
    end
  end

endmodule
